// File: rtl/clint_pkg.sv
// Shared types, register offsets and the byte-merge helper for the core-local interruptor.
package clint_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned STRB_W = XLEN / 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } clint_state_t;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   addr;
    logic [2:0]        size;
    logic [STRB_W-1:0] strobe;
    logic [XLEN-1:0]   data;
  } dbus_req_t;

  typedef struct packed {
    logic            addr_ok;
    logic            data_ok;
    logic [XLEN-1:0] data;
  } dbus_resp_t;

  // Replace each byte of old_v whose strobe bit is set with the matching byte of wdata.
  function automatic logic [XLEN-1:0] byte_merge(input logic [XLEN-1:0]   old_v,
                                                 input logic [XLEN-1:0]   wdata,
                                                 input logic [STRB_W-1:0] strb);
    logic [XLEN-1:0] res;
    res = old_v;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_timer.sv
// mtime counter with write override and registered mtime >= mtimecmp compare.
// CLINT_TICK_DIV_EN: when defined, mtime advances once every TICK_DIV clocks.
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mtime_we_i,
  input  logic [XLEN-1:0] mtime_wdata_i,
  input  logic [XLEN-1:0] mtimecmp_nxt_i,
  output logic [XLEN-1:0] mtime_o,
  output logic            trint_o
);

  logic [XLEN-1:0] mtime_q, mtime_d;
  logic            trint_q;
  logic            tick;

`ifdef CLINT_TICK_DIV_EN
  localparam logic [31:0] PRE_LAST = 32'(TICK_DIV - 1);

  logic [31:0] pre_q, pre_d;

  // Prescaler restarts whenever software rewrites mtime.
  always_comb begin
    pre_d = pre_q;
    tick  = 1'b0;
    if (mtime_we_i) begin
      pre_d = '0;
    end else if (pre_q == PRE_LAST) begin
      pre_d = '0;
      tick  = 1'b1;
    end else begin
      pre_d = pre_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_d;
  end
`else
  localparam int unsigned unused_tick_div = TICK_DIV;
  assign tick = 1'b1;
`endif

  // A software write takes priority over the increment in the same cycle.
  always_comb begin
    mtime_d = mtime_q;
    if (mtime_we_i) mtime_d = mtime_wdata_i;
    else if (tick)  mtime_d = mtime_q + XLEN'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q <= '0;
      trint_q <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      trint_q <= (mtime_d >= mtimecmp_nxt_i);
    end
  end

  assign mtime_o = mtime_q;
  assign trint_o = trint_q;

endmodule

// File: rtl/clint.sv
// Core-local interruptor: fixed-latency dbus target holding msip, mtimecmp and mtime.
// CLINT_TICK_DIV_EN: enables the mtime prescaler inside clint_timer.
module clint
  import clint_pkg::*;
#(
  parameter logic [63:0] BASE     = 64'h0000_0000_0200_0000,
  parameter int unsigned LATENCY  = 0,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       trint,
  output logic       swint
);

  localparam bit         HAS_WAIT = (LATENCY > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = HAS_WAIT ? CNT_W'(LATENCY - 1) : '0;

  clint_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dbus_req_t        req_q, req_d;
  dbus_resp_t       dresp_q, dresp_d;
  logic             msip_q, msip_d;
  logic [XLEN-1:0]  mtimecmp_q, mtimecmp_d;
  logic [XLEN-1:0]  mtime;
  logic [XLEN-1:0]  mtime_wdata;
  logic [XLEN-1:0]  rdata;
  logic             mtime_we;
  logic             base_hit, sel_msip, sel_cmp, sel_time;
  logic             unused_req;

  // Decode uses only the 8-byte lane index within the window.
  assign base_hit = (req_q.addr[63:16] == BASE[63:16]);
  assign sel_msip = base_hit && (req_q.addr[15:3] == CLINT_MSIP_OFF[15:3]);
  assign sel_cmp  = base_hit && (req_q.addr[15:3] == CLINT_MTIMECMP_OFF[15:3]);
  assign sel_time = base_hit && (req_q.addr[15:3] == CLINT_MTIME_OFF[15:3]);
  assign unused_req = ^{req_q.valid, req_q.size, req_q.addr[2:0]};

  assign mtime_wdata = byte_merge(mtime, req_q.data, req_q.strobe);

  always_comb begin
    rdata = '0;
    if (sel_msip)      rdata = {{(XLEN-1){1'b0}}, msip_q};
    else if (sel_cmp)  rdata = mtimecmp_q;
    else if (sel_time) rdata = mtime;
  end

  // Request FSM; register writes commit on the edge that leaves RESP.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_we   = 1'b0;
    dresp_d    = '0;
    case (state_q)
      IDLE: begin
        if (dreq.valid) begin
          req_d = dreq;
          cnt_d = '0;
          if (HAS_WAIT) state_d = WAIT;
          else          state_d = RESP;
        end
      end
      WAIT: begin
        if (!dreq.valid)            state_d = IDLE;
        else if (cnt_q == CNT_LAST) state_d = RESP;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      RESP: begin
        dresp_d.addr_ok = 1'b1;
        dresp_d.data_ok = 1'b1;
        dresp_d.data    = rdata;
        if (sel_msip && req_q.strobe[0]) msip_d = req_q.data[0];
        if (sel_cmp) mtimecmp_d = byte_merge(mtimecmp_q, req_q.data, req_q.strobe);
        mtime_we = sel_time && (|req_q.strobe);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      dresp_q    <= '0;
      msip_q     <= 1'b0;
      mtimecmp_q <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      dresp_q    <= dresp_d;
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
    end
  end

  clint_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_timer (
    .clk           (clk),
    .rst_n         (reset),
    .mtime_we_i    (mtime_we),
    .mtime_wdata_i (mtime_wdata),
    .mtimecmp_nxt_i(mtimecmp_d),
    .mtime_o       (mtime),
    .trint_o       (trint)
  );

  assign dresp = dresp_q;
  assign swint = msip_q;

endmodule

// File: tb/tb_clint.sv
// Randomized self-checking bench for clint against a cycle-count based register model.
module tb_clint;
  import clint_pkg::*;

  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
  localparam int unsigned LAT  = 2;
  localparam logic [63:0] A_MSIP = BASE + 64'h0000;
  localparam logic [63:0] A_CMP  = BASE + 64'h4000;
  localparam logic [63:0] A_TIME = BASE + 64'hBFF8;
  localparam logic [63:0] A_HOLE = BASE + 64'h1000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       trint, swint;

  always #5 clk = ~clk;

  clint #(.BASE(BASE), .LATENCY(LAT), .TICK_DIV(1)) dut (
    .clk  (clk),
    .reset(reset),
    .dreq (dreq),
    .dresp(dresp),
    .trint(trint),
    .swint(swint)
  );

  int n_pass = 0;
  int n_checks = 0;
  longint unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: mtime is an affine function of elapsed clocks since the last anchor.
  logic            m_msip;
  logic [63:0]     m_cmp, m_tval, last_rd;
  longint unsigned m_tcyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] bytemask(input logic [7:0] s);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  function automatic logic [63:0] model_mtime();
    return m_tval + 64'(cyc - m_tcyc);
  endfunction

  function automatic logic [63:0] model_read(input logic [63:0] addr, input logic [63:0] t);
    logic [15:0] off;
    if (addr[63:16] != BASE[63:16]) return 64'd0;
    off = {addr[15:3], 3'b000};
    case (off)
      16'h0000: return {63'd0, m_msip};
      16'h4000: return m_cmp;
      16'hBFF8: return t;
      default:  return 64'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_msip = 1'b0;
    m_cmp  = '1;
    m_tval = 64'd0;
    m_tcyc = cyc;
  endtask

  task automatic xfer(input string tag, input logic [63:0] addr, input logic [7:0] strb,
                      input logic [63:0] wdata);
    int k;
    logic [63:0] t_resp, m;
    logic [15:0] off;
    @(negedge clk);
    dreq.valid = 1'b1; dreq.addr = addr; dreq.size = 3'd3; dreq.strobe = strb; dreq.data = wdata;
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (dresp.data_ok) begin k = i; break; end
    end
    dreq.valid = 1'b0;
    check({tag, "_lat"}, 64'(k), 64'(LAT + 2));
    if (k != 0) begin
      t_resp  = model_mtime() - 64'd1;
      last_rd = dresp.data;
      check({tag, "_rdata"}, dresp.data, model_read(addr, t_resp));
      check({tag, "_addr_ok"}, 64'(dresp.addr_ok), 64'd1);
      off = {addr[15:3], 3'b000};
      m   = bytemask(strb);
      if (addr[63:16] == BASE[63:16]) begin
        if (off == 16'h0000 && strb[0]) m_msip = wdata[0];
        if (off == 16'h4000) m_cmp = (m_cmp & ~m) | (wdata & m);
        if (off == 16'hBFF8 && strb != 8'h00) begin
          m_tval = (t_resp & ~m) | (wdata & m);
          m_tcyc = cyc;
        end
      end
      check({tag, "_swint"}, 64'(swint), 64'(m_msip));
      @(negedge clk);
      check({tag, "_one_cycle"}, 64'(dresp.data_ok), 64'd0);
      check({tag, "_trint"}, 64'(trint), 64'(model_mtime() >= m_cmp));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic seen_ok;
    int   sel;
    logic [63:0] a, d;
    logic [7:0]  s;
    dreq = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_dresp", dresp.data, 64'd0);
    check("rst_ok", 64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
    check("rst_trint", 64'(trint), 64'd0);
    check("rst_swint", 64'(swint), 64'd0);
    reset = 1'b1;
    model_reset();
    repeat (10) @(negedge clk);
    check("idle_ok", 64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
    check("idle_trint", 64'(trint), 64'd0);
    check("idle_swint", 64'(swint), 64'd0);
    xfer("rd_mtime0", A_TIME, 8'h00, 64'd0);
    check("mtime_ge11", 64'(last_rd >= 64'd11), 64'd1);

    xfer("wr_msip", A_MSIP, 8'h01, 64'd1);
    xfer("rd_msip", A_MSIP + 64'h5, 8'h00, 64'd0);

    // Timer compare crossing.
    xfer("wr_cmp50", A_CMP, 8'hFF, 64'd50);
    xfer("wr_time40", A_TIME, 8'hFF, 64'd40);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("trint_poll", 64'(trint), 64'(model_mtime() >= m_cmp));
    end
    check("trint_hit", 64'(trint), 64'd1);
    xfer("wr_cmp100", A_CMP, 8'hFF, 64'd100);
    check("trint_clear", 64'(trint), 64'd0);

    // Partial-strobe write keeps the untouched upper word.
    xfer("wr_time0", A_TIME, 8'hFF, 64'd0);
    xfer("wr_time_lo", A_TIME, 8'h0F, 64'hFFFF_FFFF_FFFF_FFF0);
    xfer("rd_time_lo", A_TIME, 8'h00, 64'd0);
    check("time_hi_kept", 64'(last_rd[63:32]), 64'd0);
    xfer("wr_time_wrap", A_TIME, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE);
    xfer("rd_time_wrap", A_TIME, 8'h00, 64'd0);

    // Unmapped offset and foreign base.
    xfer("rd_hole", A_HOLE, 8'h00, 64'd0);
    xfer("wr_hole", A_HOLE, 8'hFF, 64'hDEAD_BEEF_0000_0000);
    xfer("rd_cmp_after", A_CMP, 8'h00, 64'd0);
    xfer("wr_foreign", 64'h0000_0001_0200_0000, 8'hFF, 64'd0);
    xfer("rd_msip_after", A_MSIP, 8'h00, 64'd0);

    // Abandoned request in WAIT: no response, no write.
    @(negedge clk);
    dreq.valid = 1'b1; dreq.addr = A_MSIP; dreq.strobe = 8'h01; dreq.data = 64'd0;
    @(negedge clk);
    dreq.valid = 1'b0;
    seen_ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen_ok = seen_ok | dresp.data_ok;
    end
    check("abort_no_ok", 64'(seen_ok), 64'd0);
    check("abort_swint", 64'(swint), 64'(m_msip));

    // Reset during WAIT drops everything.
    @(negedge clk);
    dreq.valid = 1'b1; dreq.addr = A_CMP; dreq.strobe = 8'hFF; dreq.data = 64'd7;
    @(negedge clk);
    reset = 1'b0;
    dreq.valid = 1'b0;
    #1;
    check("rstwait_dresp", dresp.data, 64'd0);
    check("rstwait_ok", 64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
    check("rstwait_swint", 64'(swint), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    xfer("rd_cmp_rst", A_CMP, 8'h00, 64'd0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 4));
      s = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      d = {32'($urandom_range(0, 3)), 32'($urandom_range(0, 400))};
      case (sel)
        0:       a = A_MSIP;
        1:       a = A_CMP;
        2:       a = A_TIME;
        3:       a = BASE + {48'd0, 16'($urandom)};
        default: a = {32'($urandom_range(1, 9)), 32'h0200_4000};
      endcase
      a[2:0] = 3'($urandom);
      xfer("rand", a, s, d);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
